// File: rtl/crypto_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | crypto_seq_pkg : opcodes, command-width derivation and field slicing        |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
package crypto_seq_pkg;

  localparam int unsigned OP_READ  = 0;
  localparam int unsigned OP_LOAD  = 1;
  localparam int unsigned OP_COPY  = 2;
  localparam int unsigned OP_ADD   = 3;
  localparam int unsigned OP_SUB   = 4;
  localparam int unsigned OP_MUL   = 5;
  localparam int unsigned OP_FLUSH = 6;

  function automatic int cmd_width(input int opw, input int aw);
    return opw + 3 * aw;
  endfunction

  // Words are passed zero-extended to 128 bits so one helper serves any width.
  function automatic logic [31:0] field(input logic [127:0] word,
                                        input int unsigned  lsb,
                                        input int unsigned  w);
    logic [127:0] mask;
    mask = (128'd1 << w) - 128'd1;
    return 32'((word >> lsb) & mask);
  endfunction

  function automatic logic [31:0] f_op(input logic [127:0] word, input int unsigned opw,
                                       input int unsigned aw);
    return field(word, 3 * aw, opw);
  endfunction

  function automatic logic [31:0] f_srca(input logic [127:0] word, input int unsigned aw);
    return field(word, 2 * aw, aw);
  endfunction

  function automatic logic [31:0] f_srcb(input logic [127:0] word, input int unsigned aw);
    return field(word, aw, aw);
  endfunction

  function automatic logic [31:0] f_dst(input logic [127:0] word, input int unsigned aw);
    return field(word, 0, aw);
  endfunction

endpackage
`default_nettype wire

// File: rtl/crypto_ins_sequencer_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seq_fifo : synchronous DEPTH x W command FIFO with count/full/empty         |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module seq_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 24
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PW   = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH + 1);

  logic [W-1:0]    r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CNTW-1:0] r_count;
  logic            w_do_push;
  logic            w_do_pop;

  // A full FIFO refuses a push even when it pops in the same cycle.
  assign full      = (r_count == CNTW'(DEPTH));
  assign empty     = (r_count == '0);
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;
  assign dout      = r_mem[r_rd_ptr];
  assign count     = r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= din;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNTW'(1);
        2'b01:   r_count <= r_count - CNTW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/crypto_ins_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | crypto_ins_sequencer : buffered in-order issue with multiply scoreboard     |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module crypto_ins_sequencer
  import crypto_seq_pkg::*;
#(
  parameter int AW      = 7,
  parameter int OPW     = 3,
  parameter int DEPTH   = 8,
  parameter int MAX_MUL = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [cmd_width(OPW,AW)-1:0]  cmd_in,
  output logic                          iss_valid,
  input  logic                          iss_ready,
  output logic [OPW-1:0]                iss_op,
  output logic [AW-1:0]                 iss_srca,
  output logic [AW-1:0]                 iss_srcb,
  output logic [AW-1:0]                 iss_dst,
  input  logic                          mul_done,
  input  logic [AW-1:0]                 mul_done_dst,
  output logic                          idle,
  output logic                          bad_op
);

  localparam int CW   = cmd_width(OPW, AW);
  localparam int NREG = 1 << AW;
  localparam int CNTW = $clog2(DEPTH + 1);
  localparam int MCW  = $clog2(MAX_MUL + 1);

  logic [CW-1:0]   w_head;
  logic [CNTW-1:0] w_count;
  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic [OPW-1:0]  w_op;
  logic            w_busy_a;
  logic            w_busy_b;
  logic            w_busy_d;
  logic            w_mul_full;
  logic            w_stall;
  logic            w_issuable;
  logic            w_reserved;
  logic            w_flush_pop;
  logic            w_drop;
  logic            w_mul_iss;
  logic            w_done;
  logic            r_busy [NREG];
  logic [MCW-1:0]  r_mul_cnt;
  logic            r_bad_op;

  seq_fifo #(
    .DEPTH (DEPTH),
    .W     (CW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .pop   (w_pop),
    .din   (cmd_in),
    .dout  (w_head),
    .count (w_count),
    .full  (w_full),
    .empty (w_empty)
  );

  assign w_op     = OPW'(f_op(128'(w_head), OPW, AW));
  assign iss_op   = w_op;
  assign iss_srca = AW'(f_srca(128'(w_head), AW));
  assign iss_srcb = AW'(f_srcb(128'(w_head), AW));
  assign iss_dst  = AW'(f_dst(128'(w_head), AW));

  assign cmd_ready = !w_full;
  assign w_push    = cmd_valid && cmd_ready;

  assign w_busy_a   = r_busy[iss_srca];
  assign w_busy_b   = r_busy[iss_srcb];
  assign w_busy_d   = r_busy[iss_dst];
  assign w_mul_full = (r_mul_cnt == MCW'(MAX_MUL));

  always_comb begin
    w_stall = 1'b0;
    case (w_op)
      OPW'(OP_READ), OPW'(OP_COPY): w_stall = w_busy_a;
      OPW'(OP_LOAD):                w_stall = w_busy_d;
      OPW'(OP_ADD), OPW'(OP_SUB):   w_stall = w_busy_a | w_busy_b | w_busy_d;
      OPW'(OP_MUL):                 w_stall = w_busy_a | w_busy_b | w_busy_d | w_mul_full;
      OPW'(OP_FLUSH):               w_stall = (r_mul_cnt != '0);
      default:                      w_stall = 1'b0;
    endcase
  end

  assign w_issuable  = (w_op <= OPW'(OP_MUL));
  assign w_reserved  = (w_op > OPW'(OP_FLUSH));
  assign iss_valid   = !w_empty && w_issuable && !w_stall;
  // FLUSH and reserved opcodes leave the queue without ever being presented.
  assign w_flush_pop = !w_empty && (w_op == OPW'(OP_FLUSH)) && !w_stall;
  assign w_drop      = !w_empty && w_reserved;
  assign w_pop       = (iss_valid && iss_ready) || w_flush_pop || w_drop;

  assign w_mul_iss = iss_valid && iss_ready && (w_op == OPW'(OP_MUL));
  assign w_done    = mul_done && (r_mul_cnt != '0);

  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_busy
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          r_busy[gi] <= 1'b0;
        else if (w_mul_iss && (iss_dst == AW'(gi)))
          r_busy[gi] <= 1'b1;
        else if (w_done && (mul_done_dst == AW'(gi)))
          r_busy[gi] <= 1'b0;
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mul_cnt <= '0;
      r_bad_op  <= 1'b0;
    end else begin
      case ({w_mul_iss, w_done})
        2'b10:   r_mul_cnt <= r_mul_cnt + MCW'(1);
        2'b01:   r_mul_cnt <= r_mul_cnt - MCW'(1);
        default: r_mul_cnt <= r_mul_cnt;
      endcase
      if (w_drop) r_bad_op <= 1'b1;
    end
  end

  assign bad_op = r_bad_op;
  assign idle   = (w_count == '0) && (r_mul_cnt == '0);

endmodule
`default_nettype wire

// File: tb/tb_crypto_ins_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_crypto_ins_sequencer : directed scoreboard bench for the sequencer       |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_crypto_ins_sequencer;

  localparam int AW  = 7;
  localparam int OPW = 3;
  localparam int CW  = OPW + 3 * AW;

  typedef struct packed {
    logic [2:0] op;
    logic [6:0] a;
    logic [6:0] b;
    logic [6:0] d;
  } ins_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [CW-1:0] cmd_in = '0;
  logic          iss_valid;
  logic          iss_ready = 1'b0;
  logic [OPW-1:0] iss_op;
  logic [AW-1:0] iss_srca;
  logic [AW-1:0] iss_srcb;
  logic [AW-1:0] iss_dst;
  logic          mul_done = 1'b0;
  logic [AW-1:0] mul_done_dst = '0;
  logic          idle;
  logic          bad_op;

  ins_t exp_q[$];
  int   iss_cyc_q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  ins_t mon_e;
  int   p0, dc, lc;

  crypto_ins_sequencer #(.AW(7), .OPW(3), .DEPTH(8), .MAX_MUL(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_in       (cmd_in),
    .iss_valid    (iss_valid),
    .iss_ready    (iss_ready),
    .iss_op       (iss_op),
    .iss_srca     (iss_srca),
    .iss_srcb     (iss_srcb),
    .iss_dst      (iss_dst),
    .mul_done     (mul_done),
    .mul_done_dst (mul_done_dst),
    .idle         (idle),
    .bad_op       (bad_op)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every accepted issue is matched against the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n && iss_valid && iss_ready) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL issue_unexpected: got op=%0d a=%0d b=%0d d=%0d, expected no issue",
                 iss_op, iss_srca, iss_srcb, iss_dst);
      end else begin
        mon_e = exp_q.pop_front();
        if ({iss_op, iss_srca, iss_srcb, iss_dst} !== mon_e) begin
          n_fail++;
          $display("FAIL issue_fields: got op=%0d a=%0d b=%0d d=%0d, expected op=%0d a=%0d b=%0d d=%0d",
                   iss_op, iss_srca, iss_srcb, iss_dst, mon_e.op, mon_e.a, mon_e.b, mon_e.d);
        end
      end
      iss_cyc_q.push_back(cyc);
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input int op, input int a, input int b, input int d);
    int w;
    w = 0;
    while (!cmd_ready && w < 200) begin
      tick();
      w++;
    end
    if (!cmd_ready) check("push_timeout", 32'(cmd_ready), 1);
    cmd_valid = 1'b1;
    cmd_in    = {3'(op), 7'(a), 7'(b), 7'(d)};
    tick();
    cmd_valid = 1'b0;
    if (op <= 5) exp_q.push_back(ins_t'({3'(op), 7'(a), 7'(b), 7'(d)}));
  endtask

  task automatic pulse_done(input int d);
    mul_done     = 1'b1;
    mul_done_dst = 7'(d);
    tick();
    mul_done     = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst_n = 1'b0;
    tick();
    check("rst_cmd_ready", 32'(cmd_ready), 1);
    check("rst_iss_valid", 32'(iss_valid), 0);
    check("rst_idle", 32'(idle), 1);
    check("rst_bad_op", 32'(bad_op), 0);
    check("rst_iss_fields", 32'({iss_op, iss_srca, iss_srcb, iss_dst}), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // 1: dependency chain issues back to back
    iss_ready = 1'b1;
    iss_cyc_q.delete();
    push(1, 0, 0, 0);
    p0 = cyc;
    push(1, 0, 0, 1);
    push(2, 0, 0, 2);
    push(3, 0, 0, 3);
    push(4, 3, 1, 4);
    push(5, 2, 1, 5);
    at_neg();
    check("chain_count", 32'(iss_cyc_q.size()), 6);
    check("chain_first_cycle", 32'(iss_cyc_q[0]), 32'(p0));
    check("chain_last_cycle", 32'(iss_cyc_q[5]), 32'(p0 + 5));
    repeat (3) tick();
    at_neg();
    check("chain_idle_busy", 32'(idle), 0);
    tick();
    pulse_done(5);
    at_neg();
    check("chain_idle_done", 32'(idle), 1);

    // 2: READ waits on the multiply result
    tick();
    iss_cyc_q.delete();
    push(5, 1, 2, 5);
    push(0, 5, 0, 0);
    repeat (8) tick();
    at_neg();
    check("raw_stalled", 32'(iss_valid), 0);
    tick();
    mul_done     = 1'b1;
    mul_done_dst = 7'd5;
    at_neg();
    check("raw_same_cycle", 32'(iss_valid), 0);
    tick();
    mul_done = 1'b0;
    dc = cyc;
    at_neg();
    check("raw_issue_count", 32'(iss_cyc_q.size()), 2);
    check("raw_issue_cycle", 32'(iss_cyc_q[1]), 32'(dc));

    // 3: full FIFO refuses a push even while popping
    tick();
    iss_ready = 1'b0;
    iss_cyc_q.delete();
    for (int i = 0; i < 8; i++) push(1, 0, 0, 10 + i);
    at_neg();
    check("full_cmd_ready", 32'(cmd_ready), 0);
    check("full_iss_valid", 32'(iss_valid), 1);
    check("full_head_dst", 32'(iss_dst), 10);
    tick();
    at_neg();
    check("full_head_stable", 32'(iss_dst), 10);
    tick();
    cmd_valid = 1'b1;
    cmd_in    = {3'd1, 7'd0, 7'd0, 7'd99};
    iss_ready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    check("full_ready_after_pop", 32'(cmd_ready), 1);
    for (int w = 0; w < 50 && exp_q.size() != 0; w++) tick();
    repeat (3) tick();
    at_neg();
    check("full_drain_count", 32'(iss_cyc_q.size()), 8);
    check("full_drain_idle", 32'(idle), 1);

    // 4: multiply cap, flush barrier, out-of-order completion
    tick();
    iss_cyc_q.delete();
    push(5, 20, 21, 10);
    push(5, 22, 23, 11);
    push(5, 24, 25, 12);
    push(5, 26, 27, 13);
    push(5, 28, 29, 14);
    push(6, 0, 0, 0);
    push(3, 40, 41, 30);
    repeat (2) tick();
    at_neg();
    check("cap_stalled", 32'(iss_valid), 0);
    check("cap_issued", 32'(iss_cyc_q.size()), 4);
    tick();
    mul_done     = 1'b1;
    mul_done_dst = 7'd12;
    at_neg();
    check("cap_same_cycle", 32'(iss_valid), 0);
    tick();
    mul_done = 1'b0;
    dc = cyc;
    at_neg();
    check("cap_fifth_count", 32'(iss_cyc_q.size()), 5);
    check("cap_fifth_cycle", 32'(iss_cyc_q[4]), 32'(dc));
    tick();
    tick();
    pulse_done(10);
    tick();
    pulse_done(14);
    tick();
    pulse_done(11);
    at_neg();
    check("flush_held", 32'(iss_valid), 0);
    tick();
    pulse_done(13);
    lc = cyc;
    at_neg();
    check("flush_no_valid", 32'(iss_valid), 0);
    tick();
    at_neg();
    check("flush_add_count", 32'(iss_cyc_q.size()), 6);
    check("flush_add_cycle", 32'(iss_cyc_q[5]), 32'(lc + 1));
    tick();
    mul_done     = 1'b1;
    mul_done_dst = 7'd7;
    tick();
    mul_done = 1'b0;
    at_neg();
    check("spurious_done_idle", 32'(idle), 1);

    // 5: reserved opcode
    tick();
    iss_cyc_q.delete();
    push(7, 1, 2, 3);
    repeat (2) tick();
    at_neg();
    check("bad_op_set", 32'(bad_op), 1);
    check("bad_op_no_issue", 32'(iss_cyc_q.size()), 0);
    check("bad_op_idle", 32'(idle), 1);
    tick();
    push(1, 0, 0, 44);
    at_neg();
    check("bad_op_next_issue", 32'(iss_cyc_q.size()), 1);
    repeat (3) tick();
    check("bad_op_sticky", 32'(bad_op), 1);

    // 6: asynchronous reset mid-operation
    iss_ready = 1'b1;
    push(5, 60, 61, 50);
    push(5, 62, 63, 51);
    tick();
    iss_ready = 1'b0;
    push(1, 0, 0, 70);
    push(1, 0, 0, 71);
    push(1, 0, 0, 72);
    at_neg();
    check("pre_rst_idle", 32'(idle), 0);
    #3 rst_n = 1'b0;
    #1;
    check("rst_mid_idle", 32'(idle), 1);
    check("rst_mid_iss_valid", 32'(iss_valid), 0);
    check("rst_mid_cmd_ready", 32'(cmd_ready), 1);
    check("rst_mid_bad_op", 32'(bad_op), 0);
    exp_q.delete();
    tick();
    tick();
    rst_n     = 1'b1;
    iss_ready = 1'b1;
    iss_cyc_q.delete();
    tick();
    push(1, 0, 0, 9);
    p0 = cyc;
    at_neg();
    check("post_rst_count", 32'(iss_cyc_q.size()), 1);
    check("post_rst_cycle", 32'(iss_cyc_q[0]), 32'(p0));
    tick();
    at_neg();
    check("post_rst_idle", 32'(idle), 1);
    check("final_queue_empty", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/crypto_ins_sequencer.md
# crypto_ins_sequencer

Parametrised instruction front-end for the redundant-representation field cryptoprocessor. It sits between the host command port and the register-file/ALU datapath. Incoming 24-bit-class commands are buffered in a FIFO and decoded, then issued in order. A per-register scoreboard tracks results of multi-cycle multiplies that have not yet completed, and the sequencer stalls on any data hazard against them. The earlier wrapper issued one command per cycle with no back-pressure. This block adds:
- configurable address width and queue depth;
- valid/ready handshakes on both the command side and the issue side;
- a FLUSH barrier;
- several multiplies in flight at once.

## Interface
Parameters:
- `AW`, 7 — register address width; the register file has 2^AW entries.
- `OPW`, 3 — opcode width.
- `DEPTH`, 8 — command FIFO entries; must be a power of two, ≥2.
- `MAX_MUL`, 4 — maximum number of multiplies in flight.

Command word width is CW = OPW + 3·AW (24 at defaults). Fields: op `[CW-1 -: OPW]`, srcA `[3AW-1:2AW]`, srcB `[2AW-1:AW]`, dst `[AW-1:0]`.

Ports:
- `clk`, input, 1 — single clock, rising edge.
- `rst_n`, input, 1 — asynchronous, active-low reset.
- `cmd_valid`, input, 1 — host command valid.
- `cmd_ready`, output, 1 — FIFO can accept a command.
- `cmd_in`, input, CW — command word.
- `iss_valid`, output, 1 — decoded instruction is presented to the datapath.
- `iss_ready`, input, 1 — datapath accepts the instruction.
- `iss_op`, output, OPW — opcode.
- `iss_srca`, output, AW — source A address.
- `iss_srcb`, output, AW — source B address.
- `iss_dst`, output, AW — destination address.
- `mul_done`, input, 1 — one-cycle pulse: a multiply has written its result.
- `mul_done_dst`, input, AW — destination address of the completed multiply.
- `idle`, output, 1 — FIFO empty and no multiply outstanding.
- `bad_op`, output, 1 — sticky flag: a reserved opcode was popped.

## Operation
Opcodes:
- 0 READ — output port reads srcA.
- 1 LOAD — writes dst from the data inputs.
- 2 COPY — dst ← srcA.
- 3 ADD
- 4 SUB
- 5 MUL — multi-cycle.
- 6 FLUSH — barrier.
- 7 reserved.

FIFO and command side:
- Push when `cmd_valid && cmd_ready`.
- `cmd_ready = (count < DEPTH)`. It does not depend on a same-cycle pop, so a full FIFO refuses a push even while it pops.
- Pointers wrap modulo DEPTH.

Scoreboard:
- `busy[2^AW]` holds one bit per register, plus `mul_cnt`, range 0..MAX_MUL.
- Issuing a MUL sets `busy[dst]` and increments `mul_cnt`.
- A `mul_done` pulse clears `busy[mul_done_dst]` and decrements `mul_cnt`.
- Issue and completion in the same cycle leave `mul_cnt` unchanged.

Head stall conditions, evaluated against the registered scoreboard:
- READ and COPY stall when `busy[srcA]`.
- ADD, SUB and MUL stall when `busy[srcA] | busy[srcB] | busy[dst]`.
- LOAD stalls when `busy[dst]`.
- MUL additionally stalls when `mul_cnt == MAX_MUL`.
- FLUSH stalls until `mul_cnt == 0`, is then popped without asserting `iss_valid`, and consumes one cycle.
- A reserved opcode is popped silently and sets `bad_op`; it is never issued.

Issue:
- `iss_valid` is high when the FIFO is non-empty, the head is an issuable opcode (0–5), and the head is not stalled.
- The head pops on `iss_valid && iss_ready`.
- Instructions issue strictly in order; nothing bypasses a stalled head.
- A `mul_done` that clears a hazard unblocks the head in the following cycle, not the same cycle.

Error and reset:
- A `mul_done` arriving while `mul_cnt == 0` is ignored; the count saturates at 0.
- Reset at any time, including mid-operation:
  - empties the FIFO;
  - clears all `busy` bits and `mul_cnt`;
  - clears `bad_op`;
  - drops any outstanding instruction; in-flight multiplies are forgotten.

## Timing
Reset values:
- `cmd_ready` = 1
- `iss_valid` = 0
- `idle` = 1
- `bad_op` = 0
- `iss_*` fields = 0

Latency and throughput:
- A command accepted at edge t may issue at the earliest in the cycle after edge t. There is no same-cycle fall-through.
- Sustained throughput is one issue per cycle with no hazards and `iss_ready` held high.
- The `iss_*` outputs come combinationally from the FIFO head register and the registered scoreboard; there is no path from `iss_ready` to `iss_valid`.
- `iss_*` fields stay stable while `iss_valid && !iss_ready`.
- `idle` is combinational: `(count == 0) && (mul_cnt == 0)`.

## Structure
- Shared package `crypto_seq_pkg` holds:
  - opcode localparams (`OP_READ` through `OP_FLUSH`);
  - CW derivation;
  - field-slice functions.
- One sub-module, `seq_fifo`: a parametrised synchronous FIFO with count, full and empty, DEPTH × CW.
- Scoreboard and issue logic live in the top module.

## Test plan
1. **Dependency chain**
   - Stimulus: reset; push LOAD r0, LOAD r1, COPY r2←r0, ADD r3=r0+r0, SUB r4=r3−r1, MUL r5=r2·r1, with `iss_ready = 1`.
   - Response: six issues on consecutive cycles starting one cycle after the first push; `busy[5] = 1` and `idle = 0` until `mul_done` arrives with dst 5.
2. **RAW stall on a multiply result**
   - Stimulus: MUL r5=r1·r2, then READ r5; `mul_done` for r5 arrives 10 cycles later.
   - Response: READ issues exactly one cycle after the `mul_done` pulse.
3. **Full FIFO**
   - Stimulus: `iss_ready = 0`; push DEPTH = 8 commands.
   - Response: `cmd_ready` falls after the 8th push; a 9th push with `iss_ready` raised in the same cycle is refused.
4. **MAX_MUL cap, FLUSH barrier, completion ordering**
   - Stimulus: 5 independent MULs, then FLUSH, then ADD; complete the MULs out of order.
   - Response: the 5th MUL waits for the first `mul_done`; FLUSH pops when `mul_cnt` reaches 0 and never asserts `iss_valid`; ADD issues on the next cycle.
5. **Reserved opcode**
   - Stimulus: push op 7.
   - Response: popped without `iss_valid`; `bad_op` = 1 until reset.
6. **Reset mid-operation**
   - Stimulus: assert `rst_n = 0` asynchronously with 3 commands queued and 2 MULs outstanding.
   - Response: immediately `idle = 1`, `iss_valid = 0`, `cmd_ready = 1`; after release, a fresh LOAD issues normally.
